// File: rtl/retospect_bs_loader.sv
// Host-side loader for the clockbox + cnb configuration chain. Bytes are shifted in LSB-first,
// displaced chain bits are collected as readback bytes, and a full load ends with a reset_nn pulse.
module retospect_bs_loader #(
    parameter int CHAIN_LEN = 498,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             config_en,
    output logic             bs_in,
    input  logic             bs_chain_out,
    output logic             reset_nn,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    logic [1:0]       state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [3:0]       nbits_q, nbits_d;
    logic [3:0]       sent_q, sent_d;
    logic [7:0]       rb_q, rb_d;
    logic [2:0]       rbidx_q, rbidx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rd_q, rd_d;
    logic             cfg_q, cfg_d;
    logic             bs_q, bs_d;
    logic             rnn_q, rnn_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             rdv_q, rdv_d;
    logic [CNT_W-1:0] remain;
    logic [7:0]       rb_bit;
    logic             accept;

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_ready & in_valid & ~abort;
    assign remain   = LEN - cnt_q;
    assign rb_bit   = 8'(bs_chain_out) << rbidx_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        nbits_d = nbits_q;
        sent_d  = sent_q;
        cnt_d   = cnt_q;
        rb_d    = rb_q;
        rbidx_d = rbidx_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        cfg_d   = 1'b0;
        bs_d    = 1'b0;
        rnn_d   = 1'b0;
        done_d  = 1'b0;
        rdv_d   = 1'b0;

        // An edge with config_en high displaces one chain bit: that is the readback sample.
        if (cfg_q) begin
            rb_d = rb_q | rb_bit;
            if ({1'b0, rbidx_q} == nbits_q - 4'd1) begin
                rd_d    = rb_q | rb_bit;
                rdv_d   = 1'b1;
                rb_d    = 8'd0;
                rbidx_d = 3'd0;
            end else begin
                rbidx_d = rbidx_q + 3'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // First bit goes out on the accept edge so SHIFT lasts exactly nbits cycles.
                    bs_d    = in_data[0];
                    cfg_d   = 1'b1;
                    sr_d    = in_data >> 1;
                    sent_d  = 4'd1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    nbits_d = (remain >= CNT_W'(8)) ? 4'd8 : remain[3:0];
                    rb_d    = 8'd0;
                    rbidx_d = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sent_q != nbits_q) begin
                    bs_d   = sr_q[0];
                    cfg_d  = 1'b1;
                    sr_d   = sr_q >> 1;
                    sent_d = sent_q + 4'd1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (cnt_q == LEN) begin
                    state_d = S_FINISH;
                    rnn_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort leaves the chain with whatever was already shifted and drops any partial byte.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cfg_d   = 1'b0;
            bs_d    = 1'b0;
            rnn_d   = 1'b0;
            done_d  = 1'b0;
            rdv_d   = 1'b0;
            rd_d    = rd_q;
            rb_d    = 8'd0;
            rbidx_d = 3'd0;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= 8'd0;
            nbits_q <= 4'd0;
            sent_q  <= 4'd0;
            cnt_q   <= '0;
            rb_q    <= 8'd0;
            rbidx_q <= 3'd0;
            rd_q    <= 8'd0;
            cfg_q   <= 1'b0;
            bs_q    <= 1'b0;
            rnn_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            nbits_q <= nbits_d;
            sent_q  <= sent_d;
            cnt_q   <= cnt_d;
            rb_q    <= rb_d;
            rbidx_q <= rbidx_d;
            rd_q    <= rd_d;
            cfg_q   <= cfg_d;
            bs_q    <= bs_d;
            rnn_q   <= rnn_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdv_q   <= rdv_d;
        end
    end

    assign config_en = cfg_q;
    assign bs_in     = bs_q;
    assign reset_nn  = rnn_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign rd_data   = rd_q;
    assign rd_valid  = rdv_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Bench: a short 10-bit chain and the full 498-bit chain, each driven by its own loader,
// with behavioural chain models on bs_in/bs_chain_out and images predicted from the byte stream.
module tb_retospect_bs_loader;
    localparam int NS = 10;
    localparam int NL = 498;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start[2], abort[2], in_valid[2], in_ready[2], config_en[2], bs_in[2];
    logic       bs_chain_out[2], reset_nn[2], rd_valid[2], busy[2], done[2];
    logic [7:0] in_data[2], rd_data[2];
    logic [9:0] bit_count[2];

    retospect_bs_loader #(.CHAIN_LEN(NS), .CNT_W(10)) dut_s (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .config_en(config_en[0]), .bs_in(bs_in[0]), .bs_chain_out(bs_chain_out[0]),
        .reset_nn(reset_nn[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .busy(busy[0]), .done(done[0]), .bit_count(bit_count[0]));

    retospect_bs_loader #(.CHAIN_LEN(NL), .CNT_W(10)) dut_l (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .config_en(config_en[1]), .bs_in(bs_in[1]), .bs_chain_out(bs_chain_out[1]),
        .reset_nn(reset_nn[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .busy(busy[1]), .done(done[1]), .bit_count(bit_count[1]));

    // Chain models: index 0 is the tail; a shift moves new data in at the head.
    logic [NS-1:0] ch_s = '0;
    logic [NL-1:0] ch_l = '0;
    always @(posedge clk) begin
        if (config_en[0]) ch_s <= {bs_in[0], ch_s[NS-1:1]};
        if (config_en[1]) ch_l <= {bs_in[1], ch_l[NL-1:1]};
    end
    assign bs_chain_out[0] = ch_s[0];
    assign bs_chain_out[1] = ch_l[0];

    int         n_cfg[2], n_rnn[2], n_done[2], n_bad[2], n_rdv[2], n_acc[2];
    logic       pdone[2] = '{1'b0, 1'b0};
    logic       bsq0[$];
    logic [7:0] rdq0[$], rdq1[$];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (config_en[u]) n_cfg[u]++;
            if (reset_nn[u]) n_rnn[u]++;
            if (done[u]) n_done[u]++;
            if (in_valid[u] && in_ready[u] && !abort[u]) n_acc[u]++;
            if ((reset_nn[u] !== done[u]) || (reset_nn[u] && config_en[u]) ||
                (done[u] && !busy[u]) || (pdone[u] && busy[u])) n_bad[u]++;
            pdone[u] = done[u];
            if (rd_valid[u]) begin
                n_rdv[u]++;
                if (u == 0) rdq0.push_back(rd_data[u]);
                else        rdq1.push_back(rd_data[u]);
            end
        end
        if (config_en[0]) bsq0.push_back(bs_in[0]);
    end

    int            n_cmp = 0;
    int            n_err = 0;
    logic [7:0]    tx[$];
    logic [NL-1:0] eimg[2] = '{'0, '0};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NL-1:0] got, input logic [NL-1:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Chain image after loading n bits of tx: bit i of the stream ends up at position i.
    function automatic logic [NL-1:0] img_of(input int n);
        logic [NL-1:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = tx[i/8][i%8];
        return r;
    endfunction

    function automatic logic [7:0] exp_rb(input logic [NL-1:0] img, input int n, input int j);
        logic [7:0] r = 8'd0;
        for (int k = 0; k < 8; k++) if (8*j + k < n) r[k] = img[8*j + k];
        return r;
    endfunction

    task automatic do_load(input int u, input int n, input int stall_at, input bit gaps,
                           input int start_at);
        int            nb = (n + 7) / 8;
        int            c0 = n_cfg[u];
        int            a0 = n_acc[u];
        int            d0 = n_done[u];
        int            r0 = n_rnn[u];
        int            v0 = n_rdv[u];
        int            b0 = n_bad[u];
        int            q0 = (u == 0) ? rdq0.size() : rdq1.size();
        int            t;
        int            sc;
        logic [NS-1:0] sm;
        logic [NL-1:0] prev = eimg[u];
        start[u] = 1'b1;
        step;
        start[u] = 1'b0;
        chk("busy_after_start", NL'(busy[u]), NL'(1));
        chk("in_ready_after_start", NL'(in_ready[u]), NL'(1));
        chk("bit_count_at_start", NL'(bit_count[u]), NL'(0));
        for (int j = 0; j < nb; j++) begin
            if (j == stall_at) begin
                in_valid[u] = 1'b0;
                t = 0;
                while (!in_ready[u] && t < 40) begin step; t++; end
                sc = n_cfg[u];
                sm = ch_s;
                repeat (5) step;
                chk("stall_config_en", NL'(n_cfg[u] - sc), NL'(0));
                chk("stall_chain_held", NL'(ch_s), NL'(sm));
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid[u] = 1'b0;
                repeat ($urandom_range(1, 3)) step;
            end
            if (j == start_at) start[u] = 1'b1;
            in_data[u]  = tx[j];
            in_valid[u] = 1'b1;
            t = 0;
            while (!in_ready[u] && t < 40) begin step; start[u] = 1'b0; t++; end
            chk("byte_handshake", NL'(t < 40), NL'(1));
            step;
            start[u] = 1'b0;
        end
        in_valid[u] = 1'b0;
        t = 0;
        while (!done[u] && t < 200) begin step; t++; end
        chk("done_seen", NL'(done[u]), NL'(1));
        step;
        step;
        chk("config_en_cycles", NL'(n_cfg[u] - c0), NL'(n));
        chk("bytes_accepted", NL'(n_acc[u] - a0), NL'(nb));
        chk("done_pulses", NL'(n_done[u] - d0), NL'(1));
        chk("reset_nn_pulses", NL'(n_rnn[u] - r0), NL'(1));
        chk("rd_valid_pulses", NL'(n_rdv[u] - v0), NL'(nb));
        chk("pulse_alignment", NL'(n_bad[u] - b0), NL'(0));
        chk("busy_after_done", NL'(busy[u]), NL'(0));
        chk("bit_count_final", NL'(bit_count[u]), NL'(n));
        for (int j = 0; j < nb && q0 + j < ((u == 0) ? rdq0.size() : rdq1.size()); j++)
            chk("readback_byte", NL'((u == 0) ? rdq0[q0 + j] : rdq1[q0 + j]),
                NL'(exp_rb(prev, n, j)));
        eimg[u] = img_of(n);
        chk("chain_image", (u == 0) ? NL'(ch_s) : ch_l, eimg[u]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            bq;
        logic [NS-1:0] seq;
        logic [7:0]    r;
        int            t;
        int            d0, r0, v0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; abort[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = 8'd0;
        end
        step;
        step;
        for (int u = 0; u < 2; u++)
            chk("reset_state", NL'({in_ready[u], config_en[u], bs_in[u], reset_nn[u], rd_data[u],
                                     rd_valid[u], busy[u], done[u], bit_count[u]}), NL'(0));
        reset = 1'b0;
        step;

        // Basic 10-bit load, data always valid.
        tx = '{8'hA5, 8'h03};
        bq = bsq0.size();
        do_load(0, NS, -1, 1'b0, -1);
        for (int k = 0; k < NS; k++) seq[k] = bsq0[bq + k];
        chk("bs_in_sequence", NL'(seq), NL'(10'b11_1010_0101));
        chk("model_after_load", NL'(ch_s), NL'(10'h3A5));

        // Same bytes with a 5-cycle valid gap in LOAD.
        do_load(0, NS, 1, 1'b0, -1);
        chk("stall_same_result", NL'(ch_s), NL'(10'h3A5));

        // Fill with ones, then load zeros and read the ones back.
        tx = '{8'hFF, 8'h03};
        do_load(0, NS, -1, 1'b0, -1);
        tx = '{8'h00, 8'h00};
        bq = rdq0.size();
        do_load(0, NS, -1, 1'b0, -1);
        chk("readback_ff", NL'(rdq0[bq]), NL'(8'hFF));
        chk("readback_03", NL'(rdq0[bq + 1]), NL'(8'h03));
        chk("model_zero", NL'(ch_s), NL'(0));

        // Abort after 4 bits of a random byte.
        r = 8'($urandom);
        d0 = n_done[0]; r0 = n_rnn[0]; v0 = n_rdv[0];
        start[0] = 1'b1;
        step;
        start[0] = 1'b0;
        in_data[0] = r;
        in_valid[0] = 1'b1;
        step;
        in_valid[0] = 1'b0;
        t = 0;
        while (bit_count[0] != 10'd4 && t < 20) begin step; t++; end
        abort[0] = 1'b1;
        step;
        abort[0] = 1'b0;
        chk("abort_busy", NL'(busy[0]), NL'(0));
        chk("abort_config_en", NL'(config_en[0]), NL'(0));
        chk("abort_bit_count", NL'(bit_count[0]), NL'(4));
        repeat (4) step;
        chk("abort_no_done", NL'(n_done[0] - d0), NL'(0));
        chk("abort_no_reset_nn", NL'(n_rnn[0] - r0), NL'(0));
        chk("abort_no_rd_valid", NL'(n_rdv[0] - v0), NL'(0));
        eimg[0][NS-1:0] = {r[3:0], eimg[0][NS-1:4]};
        chk("abort_chain", NL'(ch_s), eimg[0]);
        tx = '{8'($urandom), 8'($urandom)};
        do_load(0, NS, -1, 1'b0, -1);

        // Async reset in the middle of SHIFT.
        tx = '{8'($urandom), 8'($urandom)};
        start[0] = 1'b1;
        step;
        start[0] = 1'b0;
        in_data[0] = tx[0];
        in_valid[0] = 1'b1;
        step;
        step;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", NL'({in_ready[0], config_en[0], bs_in[0], reset_nn[0], rd_data[0],
                                         rd_valid[0], busy[0], done[0], bit_count[0]}), NL'(0));
        in_valid[0] = 1'b0;
        step;
        step;
        reset = 1'b0;
        step;
        eimg[0] = '0;
        eimg[0][NS-1:0] = ch_s;
        tx = '{8'($urandom), 8'($urandom)};
        do_load(0, NS, -1, 1'b0, -1);

        // Full 498-bit chain: two random loads, the second with valid gaps and a start while busy.
        tx = {};
        for (int j = 0; j < 63; j++) tx.push_back(8'($urandom));
        do_load(1, NL, -1, 1'b0, -1);
        tx = {};
        for (int j = 0; j < 63; j++) tx.push_back(8'($urandom));
        do_load(1, NL, -1, 1'b1, 20);
        chk("last_readback_2bits", NL'(rdq1[rdq1.size() - 1] & 8'hFC), NL'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
